// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC burst readout.
// FSM states, readout select codes and width derivation.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] SEL_SUM_LO = 3'd0;
  localparam logic [2:0] SEL_SUM_HI = 3'd1;
  localparam logic [2:0] SEL_MIN    = 3'd2;
  localparam logic [2:0] SEL_MAX    = 3'd3;
  localparam logic [2:0] SEL_STATUS = 3'd4;

  function automatic int cnt_w(input int n_delay);
    return $clog2(n_delay + 1);
  endfunction

  function automatic int acc_w(input int n_delay, input int log2_avg);
    return cnt_w(n_delay) + log2_avg;
  endfunction

endpackage

// File: rtl/tdc_burst_readout_therm2bin.sv
// Thermometer to binary encoder with saturation flag.
// Popcount tolerates bubbles in the delay-line code.
module tdc_therm2bin #(
  parameter int N_DELAY = 192,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_DELAY-1:0] therm_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               sat_o
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;

  // Count the ones of the synchronised thermometer word
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      cnt_d = cnt_d + CNT_W'(therm_i[i]);
    end
  end

  // Register count and top-tap saturation together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= therm_i[N_DELAY-1];
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/tdc_burst_readout.sv
// Burst-averaging readout back-end for the delay-line TDC.
// Synchronises, encodes, accumulates and muxes results to a byte.
module tdc_burst_readout
  import tdc_pkg::*;
#(
  parameter int N_DELAY  = 192,
  parameter int LOG2_AVG = 2,
  parameter int CNT_W    = cnt_w(N_DELAY),
  parameter int ACC_W    = acc_w(N_DELAY, LOG2_AVG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_DELAY-1:0] i_result,
  input  logic               i_trig,
  input  logic [2:0]         i_rd_sel,
  output logic [7:0]         o_byte,
  output logic               o_busy,
  output logic               o_valid,
  output logic               o_ovf
);

  localparam int N_SMP = 1 << LOG2_AVG;
  localparam int CYC_W = LOG2_AVG + 3;
  localparam logic [CYC_W-1:0] CYC_FIRST = CYC_W'(3);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(N_SMP + 2);

  logic [N_DELAY-1:0] s1_q, s2_q;
  logic [CNT_W-1:0]   cnt;
  logic               sat;

  state_e           state_q;
  logic [CYC_W-1:0] cyc_q;
  logic [ACC_W-1:0] wsum_q, sum_d;
  logic [CNT_W-1:0] wmin_q, min_d;
  logic [CNT_W-1:0] wmax_q, max_d;
  logic             wovf_q, ovf_d;
  logic [ACC_W-1:0] psum_q;
  logic [CNT_W-1:0] pmin_q, pmax_q;
  logic             povf_q, valid_q;
  logic [15:0]      sum16;
  logic [7:0]       byte_d;

  // Two-flop synchroniser on the asynchronous TDC word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= i_result;
      s2_q <= s1_q;
    end
  end

  tdc_therm2bin #(
    .N_DELAY (N_DELAY),
    .CNT_W   (CNT_W)
  ) u_enc (
    .clk     (clk),
    .rst_n   (rst_n),
    .therm_i (s2_q),
    .cnt_o   (cnt),
    .sat_o   (sat)
  );

  // Running statistics including the current encoder output
  always_comb begin
    sum_d = wsum_q + ACC_W'(cnt);
    min_d = (cnt < wmin_q) ? cnt : wmin_q;
    max_d = (cnt > wmax_q) ? cnt : wmax_q;
    ovf_d = wovf_q | sat;
  end

  // Burst FSM; the first three ACQ cycles wait out the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      wsum_q  <= '0;
      wmin_q  <= '0;
      wmax_q  <= '0;
      wovf_q  <= 1'b0;
      psum_q  <= '0;
      pmin_q  <= '0;
      pmax_q  <= '0;
      povf_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (i_trig) begin
            state_q <= ACQ;
            valid_q <= 1'b0;
            cyc_q   <= '0;
            wsum_q  <= '0;
            wmin_q  <= '1;
            wmax_q  <= '0;
            wovf_q  <= 1'b0;
          end
        end
        ACQ: begin
          cyc_q <= cyc_q + CYC_W'(1);
          if (cyc_q >= CYC_FIRST) begin
            wsum_q <= sum_d;
            wmin_q <= min_d;
            wmax_q <= max_d;
            wovf_q <= ovf_d;
            if (cyc_q == CYC_LAST) begin
              state_q <= DONE;
              psum_q  <= sum_d;
              pmin_q  <= min_d;
              pmax_q  <= max_d;
              povf_q  <= ovf_d;
              valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy  = (state_q == ACQ);
  assign o_valid = valid_q;
  assign o_ovf   = povf_q;
  assign sum16   = 16'(psum_q);

  // Byte-wide readout of the published registers
  always_comb begin
    byte_d = 8'h00;
    unique case (i_rd_sel)
      SEL_SUM_LO: byte_d = sum16[7:0];
      SEL_SUM_HI: byte_d = sum16[15:8];
      SEL_MIN:    byte_d = 8'(pmin_q);
      SEL_MAX:    byte_d = 8'(pmax_q);
      SEL_STATUS: byte_d = {5'b0, povf_q, valid_q, o_busy};
      default:    byte_d = 8'h00;
    endcase
  end

  assign o_byte = byte_d;

endmodule

// File: tb/tb_tdc_burst_readout.sv
// Directed bench for tdc_burst_readout.
// Default parameters: N_DELAY=192, LOG2_AVG=2.
module tb_tdc_burst_readout;

  localparam int N = 192;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] i_result = '0;
  logic         i_trig = 1'b0;
  logic [2:0]   i_rd_sel = 3'd0;
  logic [7:0]   o_byte;
  logic         o_busy, o_valid, o_ovf;

  int checks = 0;
  int errors = 0;

  tdc_burst_readout dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_result (i_result),
    .i_trig   (i_trig),
    .i_rd_sel (i_rd_sel),
    .o_byte   (o_byte),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_ovf    (o_ovf)
  );

  always #10 clk = ~clk;

  function automatic logic [N-1:0] therm(input int n);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] s, output logic [7:0] b);
    i_rd_sel = s;
    #1;
    b = o_byte;
  endtask

  // Trigger, feed four samples, wait for completion and check latency
  task automatic run_burst(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] c, input logic [N-1:0] d,
                           input bit pulse);
    logic [N-1:0] smp [4];
    int lat;
    smp[0] = a; smp[1] = b; smp[2] = c; smp[3] = d;
    i_trig = 1'b1;
    tick();
    i_trig = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL trig_busy busy=%b valid=%b required busy=1 valid=0",
               o_busy, o_valid);
    end
    for (int e = 0; e < 4; e++) begin
      i_result = smp[e];
      tick();
      if (pulse && e == 0) i_trig = 1'b1;
      if (pulse && e == 1) i_trig = 1'b0;
    end
    lat = 4;
    while (!o_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 7 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL latency got=%0d busy=%b required 7 busy=0", lat, o_busy);
    end
  endtask

  task automatic test_reset();
    logic [7:0] b;
    rst_n = 1'b0;
    #3;
    for (int s = 0; s < 8; s++) begin
      rd(3'(s), b);
      checks++;
      if (b !== 8'h00) begin
        errors++;
        $display("FAIL reset_byte sel=%0d got=%h required 00", s, b);
      end
    end
    checks++;
    if ({o_busy, o_valid, o_ovf} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b required 000",
               {o_busy, o_valid, o_ovf});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_constant();
    logic [7:0] lo, hi, mn, mx;
    run_burst(therm(37), therm(37), therm(37), therm(37), 1'b0);
    rd(3'd0, lo); rd(3'd1, hi); rd(3'd2, mn); rd(3'd3, mx);
    checks++;
    if ({hi, lo, mn, mx} !== {8'h00, 8'h94, 8'd37, 8'd37}) begin
      errors++;
      $display("FAIL const37 got=%h%h min=%0d max=%0d required 0094 37 37",
               hi, lo, mn, mx);
    end
  endtask

  task automatic test_ramp();
    logic [7:0] lo, hi, mn, mx;
    run_burst(therm(10), therm(20), therm(30), therm(40), 1'b0);
    rd(3'd0, lo); rd(3'd1, hi); rd(3'd2, mn); rd(3'd3, mx);
    checks++;
    if ({hi, lo, mn, mx} !== {8'h00, 8'd100, 8'd10, 8'd40}) begin
      errors++;
      $display("FAIL ramp got=%h%h min=%0d max=%0d required 0064 10 40",
               hi, lo, mn, mx);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] lo, hi, mx, st;
    run_burst(therm(100), therm(192), therm(100), therm(100), 1'b0);
    rd(3'd0, lo); rd(3'd1, hi); rd(3'd3, mx); rd(3'd4, st);
    checks++;
    if ({hi, lo, mx} !== {8'h01, 8'hEC, 8'd192}) begin
      errors++;
      $display("FAIL sat_sum got=%h%h max=%0d required 01ec 192", hi, lo, mx);
    end
    checks++;
    if (o_ovf !== 1'b1 || st !== 8'h06) begin
      errors++;
      $display("FAIL sat_ovf ovf=%b status=%h required 1 06", o_ovf, st);
    end
    run_burst(therm(37), therm(37), therm(37), therm(37), 1'b0);
    rd(3'd4, st);
    checks++;
    if (o_ovf !== 1'b0 || st !== 8'h02) begin
      errors++;
      $display("FAIL ovf_clear ovf=%b status=%h required 0 02", o_ovf, st);
    end
  endtask

  task automatic test_bubble_retrig();
    logic [N-1:0] bub;
    logic [7:0] lo, mn, mx;
    bub = '0;
    bub[6:0] = 7'b1101111;
    run_burst(bub, bub, bub, bub, 1'b1);
    rd(3'd0, lo); rd(3'd2, mn); rd(3'd3, mx);
    checks++;
    if ({lo, mn, mx} !== {8'd24, 8'd6, 8'd6}) begin
      errors++;
      $display("FAIL bubble sum=%0d min=%0d max=%0d required 24 6 6",
               lo, mn, mx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] lo;
    int lat;
    i_result = therm(37);
    i_trig = 1'b1;
    tick();
    lat = 0;
    while (!o_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 7) begin
      errors++;
      $display("FAIL b2b_first lat=%0d required 7", lat);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_retrig valid=%b busy=%b required 0 1",
               o_valid, o_busy);
    end
    i_trig = 1'b0;
    lat = 0;
    while (!o_valid && lat < 20) begin
      tick();
      lat++;
    end
    rd(3'd0, lo);
    checks++;
    if (lat != 7 || lo !== 8'h94) begin
      errors++;
      $display("FAIL b2b_second lat=%0d sum=%h required 7 94", lat, lo);
    end
  endtask

  task automatic test_midburst_reset();
    logic [7:0] lo, mx, mn;
    i_result = therm(50);
    i_trig = 1'b1;
    tick();
    i_trig = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    rd(3'd0, lo); rd(3'd3, mx);
    checks++;
    if ({o_busy, o_valid, o_ovf, lo, mx} !== 19'd0) begin
      errors++;
      $display("FAIL midreset busy=%b valid=%b ovf=%b sum=%h max=%h required all 0",
               o_busy, o_valid, o_ovf, lo, mx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(therm(10), therm(20), therm(30), therm(40), 1'b0);
    rd(3'd0, lo); rd(3'd2, mn); rd(3'd3, mx);
    checks++;
    if ({lo, mn, mx} !== {8'd100, 8'd10, 8'd40}) begin
      errors++;
      $display("FAIL after_reset sum=%0d min=%0d max=%0d required 100 10 40",
               lo, mn, mx);
    end
  endtask

  initial begin
    test_reset();
    tick();
    test_constant();
    test_ramp();
    test_saturation();
    test_bubble_retrig();
    test_back_to_back();
    test_midburst_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_burst_readout.md
# tdc_burst_readout

Parametrised readout back-end for the delay-line TDC. It synchronises the raw N_DELAY-bit thermometer result and encodes it to a binary tap count. It accumulates a triggered burst of 2^LOG2_AVG consecutive samples, tracking sum, min, max and overflow, and exposes the results through a byte-wide select mux. It sits between `tdc` and the 8-bit TinyTapeout output pins, replacing the plain per-clock slice mux.

## Interface
Parameters:
- N_DELAY, 192, delay-line length (multiple of 8, 8..255)
- CNT_W, $clog2(N_DELAY+1), width of one encoded sample
- LOG2_AVG, 2, burst length exponent, 0..4; N_SMP = 2^LOG2_AVG
- ACC_W, CNT_W+LOG2_AVG, accumulator width (always ≤ 16)

Ports:
- clk  in  1  single clock; also the TDC stop edge
- rst_n  in  1  reset, asynchronous, active-low
- i_result  in  N_DELAY  raw thermometer from `tdc`, asynchronous to clk
- i_trig  in  1  burst request, sampled each rising edge
- i_rd_sel  in  3  readout byte select
- o_byte  out  8  selected readout byte (combinational from registers)
- o_busy  out  1  burst in progress
- o_valid  out  1  published results belong to the last completed burst
- o_ovf  out  1  last completed burst saw a saturated line

## Operation
- Front end: two flop stages on i_result (s1, s2), then encoder register cnt = popcount(s2). Popcount gives bubble tolerance. Saturation flag sat = s2[N_DELAY-1], registered with cnt.
- FSM states: IDLE, ACQ, DONE.
  - IDLE/DONE, i_trig=1 → ACQ. Clear o_valid, clear working sum. Set working min = 2^CNT_W-1, working max = 0, working ovf = 0, sample counter = 0.
  - ACQ: accept the pipelined sample stream. Per accepted sample: sum += cnt, min = min(min,cnt), max = max(max,cnt), ovf |= sat, counter++.
  - ACQ, after the N_SMP-th accepted sample → DONE. On that same edge, load the published sum/min/max/ovf registers and set o_valid.
  - DONE holds until the next i_trig.
- i_trig in ACQ is ignored. No queueing.
- Published registers change only on burst completion. Old values stay readable while busy; o_valid=0 marks them stale.
- o_busy = (state == ACQ).
- Readout by i_rd_sel:
  - 0: sum[7:0]
  - 1: sum[15:8], zero-extended above ACC_W
  - 2: min, zero-extended to 8
  - 3: max
  - 4: {5'b0, o_ovf, o_valid, o_busy}
  - 5..7: 8'h00
- Arithmetic: unsigned. The accumulator cannot overflow by construction of ACC_W. The mean is sum >> LOG2_AVG, computed by the host.

## Timing
- Reset: all flops 0, state IDLE, o_busy=0, o_valid=0, o_ovf=0, o_byte=0 for every i_rd_sel.
- Trigger sampled at edge k:
  - o_busy=1 from k.
  - Burst samples are i_result as captured into s1 at edges k+1 … k+N_SMP.
  - Sample j (captured at k+j) reaches cnt at k+j+2 and is accumulated at k+j+3.
  - Completion, o_valid=1 and o_busy=0 at edge k+N_SMP+3. For LOG2_AVG=2 that is k+7.
- Re-trigger in DONE at edge m: o_valid drops at m, and the new completion is at m+N_SMP+3. Back-to-back bursts are therefore possible, spaced N_SMP+4 cycles apart.
- i_trig held high continuously: re-triggers on the first cycle in DONE.
- rst_n asserted mid-burst: immediate return to the reset state. Partial results are discarded; published registers are 0.
- LOG2_AVG=0: single sample; sum = min = max = that sample.

## Structure
- Package `tdc_pkg`:
  - FSM state enum (IDLE/ACQ/DONE)
  - i_rd_sel code constants (SEL_SUM_LO, SEL_SUM_HI, SEL_MIN, SEL_MAX, SEL_STATUS)
  - CNT_W/ACC_W derivation helpers
- Sub-module `tdc_therm2bin`: registered popcount plus sat flag, parameter N_DELAY. The main block holds the synchroniser, FSM, accumulators and readout mux.

## Test plan
- Reset, then every i_rd_sel 0..7 → o_byte=0x00, busy/valid/ovf all 0.
- N_DELAY=192, LOG2_AVG=2, i_result = 37 LSB ones held, trigger at edge k → o_valid at k+7, sum=148 (byte0=0x94, byte1=0x00), min=max=37, ovf=0.
- Per-cycle samples of 10, 20, 30, 40 ones → sum=100, min=10, max=40.
- One sample all-ones (192) among 100s → sum=492 (0xEC, 0x01), max=192, ovf=1. A following burst without saturation → ovf=0.
- Bubbled thermometer 0b…1101111 (6 ones) → cnt=6. i_trig pulsed during ACQ → ignored, completion time unchanged.
- rst_n low at k+3 of a burst → all outputs 0 immediately. New trigger after release completes normally with correct values.
